spi_cmd_trace_buffer: RTL and testbench

SPI_CMD_TRACE_BUFFER -- requirements
Module: spi_cmd_trace_buffer

---
 rtl/spi_trace_pkg.sv | 41 ++++
 rtl/spi_trace_ram.sv | 32 +++
 rtl/spi_cmd_trace_buffer.sv | 164 ++++++++++++++++
 tb/tb_spi_cmd_trace_buffer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_trace_pkg.sv
// Shared constants for the SPI command trace buffer: CSR map, CONTROL/STATUS bit
// positions, trace-entry field offsets and the timestamp width.
package spi_trace_pkg;

    localparam int DATA_W          = 64;
    localparam int TS_W            = 26;
    localparam int ENTRY_TS_LSB    = 38;

    localparam int CSR_STATUS      = 0;
    localparam int CSR_CONTROL     = 1;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_MODE_BIT   = 1;
    localparam int CTRL_CLEAR_BIT  = 2;

    localparam int STAT_COUNT_LSB  = 0;
    localparam int STAT_PTR_LSB    = 16;
    localparam int STAT_OVF_BIT    = 32;
    localparam int STAT_FULL_BIT   = 33;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_STOP = 1'b1
    } trace_mode_e;

    function automatic logic [DATA_W-1:0] pack_status(
        input logic [15:0] count,
        input logic [15:0] wr_ptr,
        input logic        overflow,
        input logic        full
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[STAT_COUNT_LSB +: 16] = count;
        s[STAT_PTR_LSB +: 16]   = wr_ptr;
        s[STAT_OVF_BIT]         = overflow;
        s[STAT_FULL_BIT]        = full;
        return s;
    endfunction

endpackage

// File: rtl/spi_trace_ram.sv
// Trace storage: DEPTH x DATA_W simple dual-port RAM, one write port and one
// registered read port (read-first on address collision).
module spi_trace_ram #(
    parameter int  DEPTH  = 64,
    parameter int  DATA_W = 64,
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/spi_cmd_trace_buffer.sv
// SPI command trace buffer with an Avalon-MM CSR/entry window.
// Define SPI_TRACE_TIMESTAMP_EN to stamp each entry with a 26-bit cycle counter.
module spi_cmd_trace_buffer
    import spi_trace_pkg::*;
#(
    parameter int  DEPTH = 64,
    parameter int  CMD_W = 6,
    parameter int  ARG_W = 32,
    localparam int AW    = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AW-1:0]     io_Avalon_address,
    input  logic              io_Avalon_read,
    input  logic              io_Avalon_write,
    input  logic [DATA_W-1:0] io_Avalon_writedata,
    output logic [DATA_W-1:0] io_Avalon_readdata,
    output logic              io_Avalon_readdatavalid,
    output logic              io_Avalon_waitrequest,
    input  logic [CMD_W-1:0]  io_Command,
    input  logic [ARG_W-1:0]  io_CommandArgument,
    input  logic              io_ReadSuccess,
    output logic              io_Overflow
);

    localparam int IW = AW - 1;
    localparam int CW = AW;

    logic              hist_reg;
    logic [IW-1:0]     wr_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              overflow_reg;
    logic              enable_reg;
    trace_mode_e       mode_reg;
    logic              rd_valid_reg;
    logic              rd_entry_reg;
    logic [DATA_W-1:0] csr_rdata_reg;

    logic              capture;
    logic              full;
    logic              rd_acc;
    logic              wr_acc;
    logic              is_entry;
    logic              ctrl_wr;
    logic              clear_req;
    logic              ram_we;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] entry_data;
    logic [DATA_W-1:0] csr_rdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_wdata;

    // The bus is stalled for exactly the cycle in which a capture lands, so a
    // CONTROL write never races a capture; a held write lands one cycle later.
    assign capture               = io_ReadSuccess & ~hist_reg & enable_reg & ~reset;
    assign io_Avalon_waitrequest = capture;

    assign is_entry  = io_Avalon_address[AW-1];
    assign idx       = io_Avalon_address[IW-1:0];
    assign rd_acc    = io_Avalon_read & ~capture;
    assign wr_acc    = io_Avalon_write & ~capture;
    assign full      = (count_reg == CW'(DEPTH));
    assign ctrl_wr   = wr_acc & ~is_entry & (idx == IW'(CSR_CONTROL));
    assign clear_req = ctrl_wr & io_Avalon_writedata[CTRL_CLEAR_BIT];
    assign ram_we    = capture & ~clear_req & ~(full & (mode_reg == MODE_STOP));

    assign unused_wdata = ^io_Avalon_writedata[DATA_W-1:CTRL_CLEAR_BIT+1];

`ifdef SPI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
        end
    end

    always_comb begin
        entry_data                           = '0;
        entry_data[ARG_W-1:0]                = io_CommandArgument;
        entry_data[ARG_W+CMD_W-1:ARG_W]      = io_Command;
        entry_data[ENTRY_TS_LSB +: TS_W]     = ts_reg;
    end
`else
    always_comb begin
        entry_data                           = '0;
        entry_data[ARG_W-1:0]                = io_CommandArgument;
        entry_data[ARG_W+CMD_W-1:ARG_W]      = io_Command;
        entry_data[ENTRY_TS_LSB +: TS_W]     = '0;
    end
`endif

    always_comb begin
        csr_rdata = '0;
        if (idx == IW'(CSR_STATUS)) begin
            csr_rdata = pack_status(16'(count_reg), 16'(wr_ptr_reg), overflow_reg, full);
        end else if (idx == IW'(CSR_CONTROL)) begin
            csr_rdata[CTRL_ENABLE_BIT] = enable_reg;
            csr_rdata[CTRL_MODE_BIT]   = (mode_reg == MODE_STOP);
        end
    end

    spi_trace_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (entry_data),
        .rd_en   (rd_acc & is_entry),
        .rd_addr (idx),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_reg      <= 1'b1;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            enable_reg    <= 1'b1;
            mode_reg      <= MODE_WRAP;
            rd_valid_reg  <= 1'b0;
            rd_entry_reg  <= 1'b0;
            csr_rdata_reg <= '0;
        end else begin
            hist_reg     <= io_ReadSuccess;
            rd_valid_reg <= rd_acc;
            if (rd_acc) begin
                rd_entry_reg  <= is_entry;
                csr_rdata_reg <= csr_rdata;
            end

            if (clear_req) begin
                wr_ptr_reg   <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else if (capture) begin
                if (full) begin
                    overflow_reg <= 1'b1;
                    if (mode_reg == MODE_WRAP) begin
                        wr_ptr_reg <= wr_ptr_reg + IW'(1);
                    end
                end else begin
                    wr_ptr_reg <= wr_ptr_reg + IW'(1);
                    count_reg  <= count_reg + CW'(1);
                end
            end

            if (ctrl_wr) begin
                enable_reg <= io_Avalon_writedata[CTRL_ENABLE_BIT];
                mode_reg   <= io_Avalon_writedata[CTRL_MODE_BIT] ? MODE_STOP : MODE_WRAP;
            end
        end
    end

    assign io_Avalon_readdata      = rd_entry_reg ? ram_rdata : csr_rdata_reg;
    assign io_Avalon_readdatavalid = rd_valid_reg;
    assign io_Overflow             = overflow_reg;

endmodule

// File: tb/tb_spi_cmd_trace_buffer.sv
// Directed self-checking bench for spi_cmd_trace_buffer (default parameters).
module tb_spi_cmd_trace_buffer;

    localparam int DEPTH = 64;
    localparam int AW    = 7;
`ifdef SPI_TRACE_TIMESTAMP_EN
    localparam logic [63:0] ENT_MASK = 64'h0000_003F_FFFF_FFFF;
`else
    localparam logic [63:0] ENT_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [63:0]   writedata;
    logic [63:0]   readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic [5:0]    command;
    logic [31:0]   argument;
    logic          read_success;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    spi_cmd_trace_buffer dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_Avalon_address       (address),
        .io_Avalon_read          (read),
        .io_Avalon_write         (write),
        .io_Avalon_writedata     (writedata),
        .io_Avalon_readdata      (readdata),
        .io_Avalon_readdatavalid (readdatavalid),
        .io_Avalon_waitrequest   (waitrequest),
        .io_Command              (command),
        .io_CommandArgument      (argument),
        .io_ReadSuccess          (read_success),
        .io_Overflow             (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] entry_addr(input int i);
        return {1'b1, 6'(i)};
    endfunction

    task automatic avl_read(input logic [AW-1:0] addr, output logic [63:0] data);
        @(negedge clock);
        address = addr;
        read    = 1'b1;
        @(negedge clock);
        read = 1'b0;
        check("rdvalid", 64'(readdatavalid), 64'd1);
        data = readdata;
        $display("read  addr=0x%0h data=0x%0h", addr, data);
    endtask

    task automatic avl_write(input logic [AW-1:0] addr, input logic [63:0] data);
        @(negedge clock);
        address   = addr;
        writedata = data;
        write     = 1'b1;
        @(negedge clock);
        write = 1'b0;
        $display("write addr=0x%0h data=0x%0h", addr, data);
    endtask

    task automatic pulse(input logic [5:0] cmd, input logic [31:0] arg);
        @(negedge clock);
        command      = cmd;
        argument     = arg;
        read_success = 1'b1;
        #1;
        check("wait_capture", 64'(waitrequest), 64'd1);
        @(negedge clock);
        read_success = 1'b0;
    endtask

    logic [63:0] d;
    logic [63:0] e0;
    logic [63:0] e1;

    initial begin
        reset        = 1'b1;
        address      = '0;
        read         = 1'b0;
        write        = 1'b0;
        writedata    = '0;
        command      = '0;
        argument     = '0;
        read_success = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // reset state
        check("rst_waitreq", 64'(waitrequest), 64'd0);
        check("rst_rdvalid", 64'(readdatavalid), 64'd0);
        check("rst_readdata", readdata, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        avl_read(7'd0, d); check("rst_status", d, 64'd0);
        avl_read(7'd1, d); check("rst_control", d, 64'd1);

        // single capture
        pulse(6'h11, 32'hDEAD_BEEF);
        avl_read(entry_addr(0), d); check("entry0", d & ENT_MASK, 64'h11_DEAD_BEEF);
        avl_read(7'd0, d); check("status_1", d, 64'h0001_0001);

        // level held high for 10 cycles captures once
        @(negedge clock);
        command = 6'h22; argument = 32'h1234_5678; read_success = 1'b1;
        repeat (10) @(negedge clock);
        read_success = 1'b0;
        avl_read(7'd0, d); check("status_hold", d, 64'h0002_0002);
        avl_read(entry_addr(1), d); check("entry1", d & ENT_MASK, 64'h22_1234_5678);

        // entry read in the cycle right after it is written
        @(negedge clock);
        command = 6'h33; argument = 32'hCAFE_F00D; read_success = 1'b1;
        @(negedge clock);
        read_success = 1'b0; address = entry_addr(2); read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        check("rdw_valid", 64'(readdatavalid), 64'd1);
        check("rdw_data", readdata & ENT_MASK, 64'h33_CAFE_F00D);

        // simultaneous read and write of CONTROL returns the old value
        @(negedge clock);
        address = 7'd1; writedata = 64'h2; read = 1'b1; write = 1'b1;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        check("rw_old", readdata, 64'd1);
        avl_read(7'd1, d); check("rw_new", d, 64'd2);
        avl_write(7'd1, 64'h1);

        // unmapped CSR and entry-space writes are ignored
        avl_write(7'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        avl_read(7'd2, d); check("csr2_zero", d, 64'd0);
        avl_write(entry_addr(0), 64'hFFFF_FFFF_FFFF_FFFF);
        avl_read(entry_addr(0), d); check("entry_wr_ign", d & ENT_MASK, 64'h11_DEAD_BEEF);
        avl_read(7'd0, d); check("status_3", d, 64'h0003_0003);

        // ReadSuccess high across reset release
        @(negedge clock);
        read_success = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        read_success = 1'b0;
        avl_read(7'd0, d); check("status_rst_hi", d, 64'd0);

        // WRAP mode, DEPTH+1 captures
        avl_write(7'd1, 64'h5);
        for (int i = 0; i <= DEPTH; i++) pulse(6'h2A, 32'(i));
        avl_read(7'd0, d); check("wrap_status", d, 64'h3_0001_0040);
        check("wrap_io_ovf", 64'(overflow), 64'd1);
        avl_read(entry_addr(0), d); check("wrap_entry0", d & ENT_MASK, 64'h2A_0000_0040);
        avl_read(entry_addr(1), d); check("wrap_entry1", d & ENT_MASK, 64'h2A_0000_0001);
        avl_read(entry_addr(DEPTH-1), d); check("wrap_entry63", d & ENT_MASK, 64'h2A_0000_003F);

        // STOP mode, DEPTH+3 captures
        avl_write(7'd1, 64'h7);
        for (int i = 0; i < DEPTH + 3; i++) pulse(6'h15, 32'h100 + 32'(i));
        avl_read(7'd0, d); check("stop_status", d, 64'h3_0000_0040);
        for (int i = 0; i < DEPTH; i++) begin
            avl_read(entry_addr(i), d);
            check("stop_entry", d & ENT_MASK, {26'd0, 6'h15, 32'h100 + 32'(i)});
        end

        // clear written in the same cycle as a capture (write held through stall)
        @(negedge clock);
        command = 6'h3F; argument = 32'h5555_AAAA; read_success = 1'b1;
        address = 7'd1; writedata = 64'h5; write = 1'b1;
        #1;
        check("clr_stall", 64'(waitrequest), 64'd1);
        @(negedge clock);
        read_success = 1'b0;
        #1;
        check("clr_nostall", 64'(waitrequest), 64'd0);
        @(negedge clock);
        write = 1'b0;
        avl_read(7'd0, d); check("clr_status", d, 64'd0);
        avl_read(7'd1, d); check("clr_control", d, 64'd1);
        check("clr_io_ovf", 64'(overflow), 64'd0);
        pulse(6'h01, 32'h0000_0077);
        avl_read(7'd0, d); check("post_clr_status", d, 64'h0001_0001);

        // reset in the same cycle as a read aborts it
        @(negedge clock);
        address = 7'd0; read = 1'b1; reset = 1'b1;
        @(negedge clock);
        read = 1'b0; reset = 1'b0;
        check("abort_rdv0", 64'(readdatavalid), 64'd0);
        @(negedge clock);
        check("abort_rdv1", 64'(readdatavalid), 64'd0);

        // timestamps: captures 100 cycles apart
        pulse(6'h0A, 32'h0000_000A);
        repeat (98) @(negedge clock);
        pulse(6'h0B, 32'h0000_000B);
        avl_read(entry_addr(0), e0);
        avl_read(entry_addr(1), e1);
        check("ts_e0_low", e0 & 64'h3F_FFFF_FFFF, 64'h0A_0000_000A);
        check("ts_e1_low", e1 & 64'h3F_FFFF_FFFF, 64'h0B_0000_000B);
`ifdef SPI_TRACE_TIMESTAMP_EN
        check("ts_diff", 64'(26'(e1[63:38] - e0[63:38])), 64'd100);
`else
        check("ts_zero0", 64'(e0[63:38]), 64'd0);
        check("ts_zero1", 64'(e1[63:38]), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
